// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage data-memory access controller for the RV32I pipeline.
// Turns single-cycle load/store requests into a req/ack transaction with a
// variable-latency backing memory and raises StallM while the access is pending.
// Optional last-read buffer: define MEM_STALL_LASTREAD_BUF_EN to enable a
// one-entry cache of the last completed load (hits complete with no stall).
module mem_stall_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] AddrM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [3:0]            ByteEnM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  ErrorM,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemBe,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  access;
    logic                  hit;
    logic                  timeout;
    logic                  unused_addr_lsb;

    // Memory accesses are word-granular; byte offset is carried by ByteEnM.
    assign unused_addr_lsb = ^AddrM[1:0];

    assign access  = MemReadM | MemWriteM;
    assign timeout = (state == REQ) && !MemAck && (wait_cnt == CNT_LAST);

`ifdef MEM_STALL_LASTREAD_BUF_EN
    logic                  buf_vld;
    logic [ADDR_WIDTH-3:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;

    assign hit = (state == IDLE) && MemReadM && !MemWriteM && buf_vld &&
                 (buf_addr == AddrM[ADDR_WIDTH-1:2]);

    // Hits bypass the registered load data so the pipeline never stalls on them.
    assign ReadDataM = hit ? buf_data : rdata_q;

    // Last-read buffer: fill on load completion, merge matching stores, drop on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (state == REQ) begin
            if (MemAck) begin
                if (!MemWe) begin
                    buf_vld  <= 1'b1;
                    buf_addr <= MemAddr[ADDR_WIDTH-1:2];
                    buf_data <= MemRData;
                end else if (buf_vld && (buf_addr == MemAddr[ADDR_WIDTH-1:2])) begin
                    for (int i = 0; i < 4; i++) begin
                        if (MemBe[i]) buf_data[8*i +: 8] <= MemWData[8*i +: 8];
                    end
                end
            end else if (timeout) begin
                buf_vld <= 1'b0;
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign ReadDataM = rdata_q;
`endif

    // Stall is combinational in IDLE so the hazard unit sees it the cycle the access arrives.
    assign StallM = !rst && ((state == REQ) || ((state == IDLE) && access && !hit));

    // Access FSM with registered memory-side outputs, load data and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
            ErrorM   <= 1'b0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemBe    <= 4'b0000;
        end else begin
            ErrorM <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        // Both read and write set is treated as a store.
                        MemReq   <= 1'b1;
                        MemWe    <= MemWriteM;
                        MemAddr  <= {AddrM[ADDR_WIDTH-1:2], 2'b00};
                        MemWData <= WriteDataM;
                        MemBe    <= ByteEnM;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end else if (hit) begin
                        rdata_q <= ReadDataM;
                    end
                end
                REQ: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        if (!MemWe) rdata_q <= MemRData;
                        state <= DONE;
                    end else if (timeout) begin
                        MemReq  <= 1'b0;
                        rdata_q <= '0;
                        ErrorM  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The instruction still sitting in M is the one just completed.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: randomized and directed bench for mem_stall_ctrl against a
// transaction-level reference model (latency per access chosen by the bench).
module tb_mem_stall_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        ErrorM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRData;

    int total = 0;
    int bad   = 0;

    // Reference model state: load data seen by W, and the last-read buffer.
    logic [31:0] m_rdata;
    bit          m_bvld;
    logic [29:0] m_baddr;
    logic [31:0] m_bdata;

    mem_stall_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemReadM(MemReadM),
        .MemWriteM(MemWriteM),
        .AddrM(AddrM),
        .WriteDataM(WriteDataM),
        .ByteEnM(ByteEnM),
        .ReadDataM(ReadDataM),
        .StallM(StallM),
        .ErrorM(ErrorM),
        .MemReq(MemReq),
        .MemWe(MemWe),
        .MemAddr(MemAddr),
        .MemWData(MemWData),
        .MemBe(MemBe),
        .MemAck(MemAck),
        .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata = '0;
        m_bvld  = 1'b0;
        m_baddr = '0;
        m_bdata = '0;
    endtask

    // One cycle with no memory instruction in M.
    task automatic idle_cycle();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        MemAck    = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'b0, StallM}, 32'd0);
        chk("idle_req", {31'b0, MemReq}, 32'd0);
        chk("idle_err", {31'b0, ErrorM}, 32'd0);
        chk("idle_rdata", ReadDataM, m_rdata);
        @(posedge clk);
        #1;
    endtask

    // One access; lat = REQ cycle in which the memory acks (lat > T means no ack in time).
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int lat, input logic [31:0] rdat);
        bit is_load;
        bit hit;
        bit tmo;
        int nreq;
        is_load    = r && !w;
        MemReadM   = r;
        MemWriteM  = w;
        AddrM      = a;
        WriteDataM = wd;
        ByteEnM    = be;
        MemAck     = 1'b0;
`ifdef MEM_STALL_LASTREAD_BUF_EN
        hit = is_load && m_bvld && (m_baddr == a[31:2]);
`else
        hit = 1'b0;
`endif
        if (hit) begin
            @(negedge clk);
            chk("hit_stall", {31'b0, StallM}, 32'd0);
            chk("hit_req", {31'b0, MemReq}, 32'd0);
            chk("hit_rdata", ReadDataM, m_bdata);
            m_rdata = m_bdata;
            @(posedge clk);
            #1;
            return;
        end
        tmo  = (lat > T);
        nreq = tmo ? T : lat;
        @(negedge clk);
        chk("issue_stall", {31'b0, StallM}, 32'd1);
        chk("issue_req", {31'b0, MemReq}, 32'd0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= nreq; k++) begin
            MemAck   = (k == lat);
            MemRData = (k == lat) ? rdat : $urandom;
            @(negedge clk);
            chk("req_req", {31'b0, MemReq}, 32'd1);
            chk("req_stall", {31'b0, StallM}, 32'd1);
            chk("req_err", {31'b0, ErrorM}, 32'd0);
            chk("req_addr", MemAddr, {a[31:2], 2'b00});
            chk("req_we", {31'b0, MemWe}, {31'b0, w});
            chk("req_be", {28'b0, MemBe}, {28'b0, be});
            chk("req_wdata", MemWData, wd);
            chk("req_rdata_hold", ReadDataM, m_rdata);
            @(posedge clk);
            #1;
        end
        // A late ack lands in the DONE cycle after a timeout and must be ignored.
        MemAck   = tmo;
        MemRData = $urandom;
        if (tmo) begin
            m_rdata = '0;
            m_bvld  = 1'b0;
        end else if (is_load) begin
            m_rdata = rdat;
            m_bvld  = 1'b1;
            m_baddr = a[31:2];
            m_bdata = rdat;
        end else if (m_bvld && (m_baddr == a[31:2])) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_bdata[8*i +: 8] = wd[8*i +: 8];
            end
        end
        @(negedge clk);
        chk("done_stall", {31'b0, StallM}, 32'd0);
        chk("done_req", {31'b0, MemReq}, 32'd0);
        chk("done_err", {31'b0, ErrorM}, {31'b0, tmo});
        chk("done_rdata", ReadDataM, m_rdata);
        @(posedge clk);
        #1;
        MemAck = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        AddrM      = 32'h0;
        WriteDataM = 32'h0;
        ByteEnM    = 4'h0;
        MemAck     = 1'b0;
        MemRData   = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a load present to confirm the stall is held off.
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        chk("rst_req", {31'b0, MemReq}, 32'd0);
        chk("rst_err", {31'b0, ErrorM}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_we", {31'b0, MemWe}, 32'd0);
        chk("rst_be", {28'b0, MemBe}, 32'd0);
        MemReadM = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        idle_cycle();

        // Directed: load 0x100 acked in the third REQ cycle.
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3, 32'hDEADBEEF);
        chk("load_data_const", ReadDataM, 32'hDEADBEEF);
        idle_cycle();
        // Directed: byte store to 0x203.
        access(1'b0, 1'b1, 32'h203, 32'h12345678, 4'b1000, 2, 32'h0);
        idle_cycle();
        // Directed: timeout with no ack, followed by idle.
        access(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 9, 32'h0);
        idle_cycle();
        // Directed: back-to-back loads with single-cycle ack.
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1, 32'h11111111);
        access(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1, 32'h22222222);
        idle_cycle();
        // Directed: ack exactly in the last allowed cycle wins over timeout.
        access(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, T, 32'h0BADF00D);
        idle_cycle();

        // Directed: reset in the middle of a request.
        MemReadM = 1'b1;
        AddrM    = 32'h44;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_req_before", {31'b0, MemReq}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, MemReq}, 32'd0);
        chk("mid_rst_stall", {31'b0, StallM}, 32'd0);
        chk("mid_rst_rdata", ReadDataM, 32'd0);
        MemReadM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle_cycle();
        access(1'b1, 1'b0, 32'h48, 32'h0, 4'hF, 2, 32'hCAFEF00D);
        idle_cycle();

`ifdef MEM_STALL_LASTREAD_BUF_EN
        // Buffer: load, merging byte store, then a hitting load.
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1, 32'hAA55AA55);
        idle_cycle();
        access(1'b0, 1'b1, 32'h40, 32'h000000FF, 4'b0001, 2, 32'h0);
        idle_cycle();
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1, 32'h0);
        chk("buf_hit_const", ReadDataM, 32'hAA55AAFF);
        idle_cycle();
`endif

        // Randomized traffic over a small address window so buffer hits recur.
        for (int n = 0; n < 250; n++) begin
            int          kind;
            int          gap;
            logic [31:0] a;
            logic [3:0]  be;
            kind = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            a    = 32'($urandom_range(0, 31));
            be   = 4'($urandom_range(0, 15));
            for (int g = 0; g < gap; g++) idle_cycle();
            access(kind == 0 || kind == 2 || kind == 3, kind == 1 || kind == 2,
                   a, $urandom, be, $urandom_range(1, 6), $urandom);
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Multi-cycle data-memory access controller in the MEM stage of the 5-stage RV32I pipeline.
- Converts single-cycle load/store requests from the MEM stage into a req/ack transaction with a variable-latency backing memory.
- Raises StallM toward the hazard unit, which freezes F/D/E/M and bubbles W while StallM is high.
- Sits upstream of the hazard unit: it produces the stall request that the hazard unit consumes.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width; fixed at 32 for RV32I.
- TIMEOUT_CYCLES, 255, maximum number of WAIT cycles before the access is aborted. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- AddrM  in  ADDR_WIDTH  byte address from ALU
- WriteDataM  in  DATA_WIDTH  store data, already lane-aligned
- ByteEnM  in  4  byte-lane enables
- ReadDataM  out  DATA_WIDTH  load data to the W-stage register
- StallM  out  1  stall request to hazard unit
- ErrorM  out  1  one-cycle pulse on access timeout
- MemReq  out  1  backing-memory request
- MemWe  out  1  1 = write
- MemAddr  out  ADDR_WIDTH  word-aligned address; bits [1:0] forced to 0
- MemWData  out  DATA_WIDTH  write data
- MemBe  out  4  byte enables
- MemAck  in  1  backing memory done; one-cycle pulse
- MemRData  in  DATA_WIDTH  read data, valid when MemAck=1

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; MemReq=0; MemWe=0; MemAddr=0; MemWData=0; MemBe=0.
  - ReadDataM=0; ErrorM=0; wait counter=0.
  - StallM=0 while rst is high.
- State IDLE:
  - Access = MemReadM | MemWriteM.
  - StallM = Access, combinationally, so the stall is visible in the same cycle the instruction reaches MEM.
  - On a clock edge with Access=1: latch AddrM, WriteDataM, ByteEnM and type; go to REQ. MemReq rises in the following cycle (registered).
- Both MemReadM and MemWriteM high: treated as a store; ReadDataM is unchanged.
- State REQ:
  - MemReq=1; MemWe/MemAddr/MemWData/MemBe held stable; StallM=1.
  - Wait counter increments each cycle.
  - MemAck=1: capture MemRData into ReadDataM (loads only); drop MemReq at the next edge; go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: ReadDataM=0, ErrorM=1 for exactly one cycle (the DONE cycle), MemReq dropped; go to DONE.
  - A late MemAck arriving after a timeout is ignored.
- State DONE:
  - StallM=0 for exactly one cycle so the pipeline advances the completed instruction into W; ReadDataM is valid this cycle.
  - The instruction still in M this cycle is never re-issued.
  - Next state is IDLE unconditionally.
- Latency: load/store stall cycles = memory latency + 1. Example: MemAck one cycle after MemReq gives StallM high for 2 cycles, then 1 DONE cycle.
- Back-to-back accesses: a second access reaching M on the cycle after DONE is handled from IDLE with no extra gap.
- Non-memory instructions in IDLE: StallM=0, no MemReq, ReadDataM holds its last value.
- Reset mid-transaction: MemReq drops asynchronously. The backing memory must tolerate an abandoned request.
- MemAck while state≠REQ: ignored.

Optional Feature:
- Macro: MEM_STALL_LASTREAD_BUF_EN.
- When defined, the block holds a one-entry buffer: valid bit, word address and data of the last completed load.
- Hit = IDLE & MemReadM & !MemWriteM & valid & word address match.
  - On a hit: StallM=0 and ReadDataM = buffer data in the same cycle (combinational path); no MemReq.
- Store to a matching word: merge bytes per ByteEnM into the buffer when that store completes.
- Timeout on any access: clears valid.
- Reset: clears valid.
- When undefined: no buffer; every load takes the full REQ/DONE path.

Test Plan:
- Load at 0x100, MemAck 3 cycles after MemReq with MemRData=0xDEADBEEF:
  - StallM high for 4 cycles, then low for 1.
  - ReadDataM=0xDEADBEEF in the DONE cycle.
  - MemAddr=0x100, MemWe=0.
- Store 0x12345678 to 0x203 with ByteEnM=4'b1000:
  - MemAddr=0x200, MemBe=4'b1000, MemWe=1.
  - MemReq held stable until MemAck; ReadDataM unchanged.
- TIMEOUT_CYCLES=4, no MemAck:
  - MemReq high for exactly 4 cycles.
  - ErrorM=1 for one cycle; ReadDataM=0; StallM released.
  - A later MemAck causes no change.
- Two consecutive loads (0x10, 0x14), each acked after 1 cycle:
  - Two separate REQ phases, each followed by one DONE cycle with StallM=0.
  - No duplicate request.
- Assert rst while in REQ:
  - MemReq=0 and StallM=0 immediately.
  - After release the state is IDLE and the next access starts cleanly.
- With MEM_STALL_LASTREAD_BUF_EN defined:
  - Load 0x40 (data 0xAA55AA55), then a store of 0x000000FF with ByteEnM=4'b0001 to 0x40, then load 0x40.
  - The second load gives StallM=0, no MemReq, ReadDataM=0xAA55AAFF.
